mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 103 ++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: holds MAR/MDR and sequences a single-port synchronous RAM
// with a registered read address, reporting completion through a busy/done handshake.
//
// state   | meaning
// IDLE    | waiting; MAR/MDR loads accepted, requests accepted
// RD_ADDR | read strobe; RAM registers the address on this edge
// RD_CAP  | read strobe; MDR captures ram_q on this edge
// WR      | write strobe; RAM writes MDR at MAR on this edge
// DONE    | one-cycle done pulse; MAR/MDR loads accepted, requests ignored
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  req_rd,
    input  logic                  req_wr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_read,
    output logic                  ram_write,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_CAP  = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        busy      = 1'b0;
        done      = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;

        // Loads in IDLE take effect on the same edge as a request, so the access sees them.
        if (state_q == IDLE || state_q == DONE) begin
            if (MARin) mar_d = bus_in[ADDR_WIDTH-1:0];
            if (MDRin) mdr_d = bus_in;
        end

        case (state_q)
            IDLE: begin
                if (req_rd)      state_d = RD_ADDR;
                else if (req_wr) state_d = WR;
            end
            RD_ADDR: begin
                busy     = 1'b1;
                ram_read = 1'b1;
                state_d  = RD_CAP;
            end
            RD_CAP: begin
                busy     = 1'b1;
                ram_read = 1'b1;
                mdr_d    = ram_q;
                state_d  = DONE;
            end
            WR: begin
                busy      = 1'b1;
                ram_write = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdr_out  = mdr_q;
    assign ram_addr = mar_q;
    assign ram_data = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a RAM model with registered read address,
// a reference memory/MAR/MDR model, and a monitor that checks every done pulse.
module tb_mem_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          clr;
    logic [DW-1:0] bus_in;
    logic          MARin, MDRin, req_rd, req_wr;
    logic          busy, done, ram_read, ram_write;
    logic [DW-1:0] mdr_out, ram_data, ram_q;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
        .req_rd(req_rd), .req_wr(req_wr), .busy(busy), .done(done),
        .mdr_out(mdr_out), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_read(ram_read), .ram_write(ram_write), .ram_q(ram_q)
    );

    // Single-port RAM, powers up to all ones, read address registered.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [AW-1:0] raddr_q;
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '1;
        raddr_q = '0;
    end
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_data;
        if (ram_read)  raddr_q <= ram_addr;
    end
    assign ram_q = ram_mem[raddr_q];

    // Reference model
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [AW-1:0] m_mar;
    logic [DW-1:0] m_mdr;

    typedef struct {
        bit            is_wr;
        logic [DW-1:0] mdr;
        logic [AW-1:0] addr;
        int            req_cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    bit prev_done = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!clr) begin
            if (ram_write) wr_cnt++;
            if (ram_read && ram_write) chk("rd_wr_exclusive", 32'(ram_read & ram_write), 32'd0);
            if (done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                chk("busy_low_in_done", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(e.is_wr ? "wr_mdr" : "rd_mdr", mdr_out, e.mdr);
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("done_latency", 32'(cyc - e.req_cyc), e.is_wr ? 32'd1 : 32'd2);
                    chk("write_strobe_cycles", 32'(wr_cnt), e.is_wr ? 32'd1 : 32'd0);
                end
                wr_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic clear_inputs();
        MARin = 0; MDRin = 0; req_rd = 0; req_wr = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 12 && (busy || done)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12) chk("access_timeout", 32'd1, 32'd0);
    endtask

    // Drive one IDLE-state cycle of loads and/or requests, updating the model.
    task automatic access(input bit rd, input bit wr, input bit ldmar, input bit ldmdr,
                          input logic [DW-1:0] busv);
        exp_t e;
        @(negedge clk);
        if (ldmar) m_mar = busv[AW-1:0];
        if (ldmdr) m_mdr = busv;
        if (rd) begin
            m_mdr = ref_mem[m_mar];
            e = '{is_wr: 1'b0, mdr: m_mdr, addr: m_mar, req_cyc: cyc + 1};
            sb.push_back(e);
        end else if (wr) begin
            ref_mem[m_mar] = m_mdr;
            e = '{is_wr: 1'b1, mdr: m_mdr, addr: m_mar, req_cyc: cyc + 1};
            sb.push_back(e);
        end
        bus_in = busv; MARin = ldmar; MDRin = ldmdr; req_rd = rd; req_wr = wr;
        @(negedge clk);
        clear_inputs();
        bus_in = $urandom;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '1;
        m_mar = '0; m_mdr = '0;
        clr = 1'b1; bus_in = '0;
        clear_inputs();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_read", 32'(ram_read), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_mdr", mdr_out, 32'd0);
        chk("rst_mar", 32'(ram_addr), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // 1: write 0xDEADBEEF at 5, then read it back
        access(0, 0, 1, 0, 32'h0000_0005);
        access(0, 0, 0, 1, 32'hDEAD_BEEF);
        access(0, 1, 0, 0, 32'h0);
        access(0, 0, 0, 1, 32'h0);
        chk("mdr_cleared", mdr_out, 32'd0);
        access(1, 0, 0, 0, 32'h0);
        chk("readback_5", mdr_out, 32'hDEAD_BEEF);

        // 2: unwritten top location
        access(1, 0, 1, 0, 32'h0000_01FF);
        chk("unwritten_1ff", mdr_out, 32'hFFFF_FFFF);

        // 3: truncation and read-over-write priority
        access(0, 0, 1, 0, 32'h0000_0003);
        access(0, 0, 0, 1, 32'h1111_2222);
        access(0, 1, 0, 0, 32'h0);
        access(0, 0, 0, 1, 32'h0BAD_F00D);
        access(1, 1, 1, 0, 32'h0000_0203);
        chk("trunc_addr", 32'(ram_addr), 32'h003);
        access(1, 0, 0, 0, 32'h0);
        chk("mem3_unchanged", mdr_out, 32'h1111_2222);

        // 4: inputs ignored while busy
        begin
            exp_t e;
            @(negedge clk);
            m_mdr = ref_mem[m_mar];
            e = '{is_wr: 1'b0, mdr: m_mdr, addr: m_mar, req_cyc: cyc + 1};
            sb.push_back(e);
            req_rd = 1;
            @(negedge clk);
            clear_inputs();
            bus_in = 32'h1234_5678; MARin = 1; MDRin = 1; req_wr = 1;
            @(negedge clk);
            clear_inputs();
            wait_idle();
            chk("busy_mar_frozen", 32'(ram_addr), 32'h003);
            chk("busy_mdr_ramdata", mdr_out, 32'h1111_2222);
        end

        // 5: reset during the write
        access(0, 0, 0, 1, 32'hCAFE_F00D);
        @(negedge clk);
        bus_in = 32'h0000_0020; MARin = 1; req_wr = 1;
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        clear_inputs();
        sb.delete();
        wr_cnt = 0;
        m_mar = '0; m_mdr = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ram_write", 32'(ram_write), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mdr", mdr_out, 32'd0);
        chk("abort_mar", 32'(ram_addr), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        access(1, 0, 1, 0, 32'h0000_0020);
        chk("aborted_write_absent", mdr_out, 32'hFFFF_FFFF);

        // 6: same-edge MAR load and read
        access(1, 0, 1, 0, 32'h0000_0005);
        chk("same_edge_read", mdr_out, 32'hDEAD_BEEF);

        // Random traffic over a small address window so reads hit earlier writes
        for (int k = 0; k < 60; k++) begin
            logic [DW-1:0] a, d;
            int op;
            a  = ($urandom & ~32'h1FF) | 32'($urandom_range(0, 15));
            d  = $urandom;
            op = $urandom_range(0, 2);
            if (op != 0) access(0, 0, 0, 1, d);
            access(op != 1, op != 0, 1'($urandom_range(0, 1)) | (k < 4), 0, a);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
